// File: rtl/gray_pkg.sv
// Shared slot-state encoding and default widths for the Gray converter/arbiter.
package gray_pkg;
  localparam int GRAY_W_DEF  = 4;
  localparam int GRAY_CW_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/bin2gray.sv
// Binary to reflected Gray code; purely combinational, zero latency, no flow control.
module bin2gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);
  assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/gray_conv_arb.sv
// Two-port round-robin arbiter feeding one Gray converter into a single-entry output slot.
// Result valid the cycle after accept; both readies drop while the slot is full and out_ready is low.
module gray_conv_arb
  import gray_pkg::*;
#(
  parameter int W  = GRAY_W_DEF,
  parameter int CW = GRAY_CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  input  logic [W-1:0]  in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [W-1:0]  in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_gray,
  output logic          out_src,
  output logic [CW-1:0] xfer_cnt
);
  slot_state_t r_state;
  slot_state_t w_state_nxt;
  logic          r_last;
  logic [W-1:0]  r_gray;
  logic          r_src;
  logic [CW-1:0] r_cnt;

  logic          w_slot_free;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_accept;
  logic [W-1:0]  w_bin;
  logic [W-1:0]  w_gray;

  assign w_slot_free = (r_state == ST_EMPTY) || out_ready;

  // r_last holds the most recently accepted port; on a tie the other one wins.
  assign w_gnt0 = in0_valid && (!in1_valid || r_last);
  assign w_gnt1 = in1_valid && (!in0_valid || !r_last);

  // rst_n gating keeps both readies low for the whole time reset is held.
  assign in0_ready = rst_n && w_slot_free && w_gnt0;
  assign in1_ready = rst_n && w_slot_free && w_gnt1;
  assign w_accept  = in0_ready || in1_ready;

  assign w_bin = w_gnt1 ? in1_data : in0_data;

  bin2gray #(.W(W)) u_bin2gray (
    .i_bin  (w_bin),
    .o_gray (w_gray)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_gray <= '0;
      r_src  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt1;
      r_gray <= w_gray;
      r_src  <= w_gnt1;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_gray  = r_gray;
  assign out_src   = r_src;
  assign xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_gray_conv_arb.sv
// Bench for gray_conv_arb: vector table, scoreboard and multi-cycle corner sequences.
module tb_gray_conv_arb;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in0_valid = 1'b0;
  logic [W-1:0]  in0_data = '0;
  logic          in0_ready;
  logic          in1_valid = 1'b0;
  logic [W-1:0]  in1_data = '0;
  logic          in1_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_gray;
  logic          out_src;
  logic [CW-1:0] xfer_cnt;

  always #5 clk = ~clk;

  gray_conv_arb #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_src   (out_src),
    .xfer_cnt  (xfer_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] gray_ref(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W-1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  typedef struct {
    logic         src;
    logic [W-1:0] gray;
  } exp_t;
  exp_t sb[$];

  int           exp_cnt   = 0;
  logic         prev_acc  = 1'b0;
  logic         prev_ov   = 1'b0;
  logic         prev_ordy = 1'b0;
  logic [W-1:0] prev_gray = '0;
  logic         prev_src  = 1'b0;

  // Scoreboard monitor: pushes on every observed accept, pops on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      exp_cnt  = 0;
      prev_acc = 1'b0;
      prev_ov  = 1'b0;
    end else begin
      check("xfer_cnt", int'(xfer_cnt), exp_cnt % (1 << CW));
      check("ready_excl", int'(in0_ready & in1_ready), 0);
      if (prev_acc) check("latency_ov", int'(out_valid), 1);
      if (prev_ov && !prev_ordy) begin
        check("hold_ov", int'(out_valid), 1);
        check("hold_gray", int'(out_gray), int'(prev_gray));
        check("hold_src", int'(out_src), int'(prev_src));
      end
      if (out_valid && out_ready) begin
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_gray", int'(out_gray), int'(e.gray));
          check("sb_src", int'(out_src), int'(e.src));
        end
      end
      prev_acc = 1'b0;
      if ((in0_valid && in0_ready) || (in1_valid && in1_ready)) begin
        e.src  = in1_valid && in1_ready;
        e.gray = gray_ref(e.src ? in1_data : in0_data);
        sb.push_back(e);
        exp_cnt++;
        prev_acc = 1'b1;
      end
      prev_ov   = out_valid;
      prev_ordy = out_ready;
      prev_gray = out_gray;
      prev_src  = out_src;
    end
  end

  typedef struct {
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         ordy;
    logic         e_r0;
    logic         e_r1;
    logic         e_ov;
  } vec_t;
  vec_t tab[12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic g;
    tab[0]  = '{1'b1, 4'h3, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[1]  = '{1'b1, 4'h3, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1};
    tab[2]  = '{1'b1, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[3]  = '{1'b0, 4'hA, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[4]  = '{1'b0, 4'hA, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1};
    tab[5]  = '{1'b1, 4'hB, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1};
    tab[6]  = '{1'b0, 4'hB, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1};
    tab[7]  = '{1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[8]  = '{1'b1, 4'h1, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[9]  = '{1'b1, 4'h1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1};
    tab[10] = '{1'b0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};
    tab[11] = '{1'b0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state, with requests pending so the ready gating is exercised.
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    #12;
    check("rst_ov", int'(out_valid), 0);
    check("rst_gray", int'(out_gray), 0);
    check("rst_src", int'(out_src), 0);
    check("rst_cnt", int'(xfer_cnt), 0);
    check("rst_r0", int'(in0_ready), 0);
    check("rst_r1", int'(in1_ready), 0);

    // Single port, usable on the first edge after release.
    @(posedge clk); #1;
    rst_n = 1'b1;
    in1_valid = 1'b0;
    in0_valid = 1'b1;
    in0_data  = 4'b0101;
    out_ready = 1'b1;
    @(negedge clk);
    check("single_r0", int'(in0_ready), 1);
    check("single_r1", int'(in1_ready), 0);
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    check("single_ov", int'(out_valid), 1);
    check("single_gray", int'(out_gray), 4'b0111);
    check("single_src", int'(out_src), 0);
    @(negedge clk);
    check("idle_ov", int'(out_valid), 0);
    check("idle_gray_hold", int'(out_gray), 4'b0111);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      in0_valid = tab[i].v0;
      in0_data  = tab[i].d0;
      in1_valid = tab[i].v1;
      in1_data  = tab[i].d1;
      out_ready = tab[i].ordy;
      @(negedge clk);
      check($sformatf("tab%0d_r0", i), int'(in0_ready), int'(tab[i].e_r0));
      check($sformatf("tab%0d_r1", i), int'(in1_ready), int'(tab[i].e_r1));
      check($sformatf("tab%0d_ov", i), int'(out_valid), int'(tab[i].e_ov));
    end

    // Continuous tie: port 0 won last, so grants run 1,0,1,0,...
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      in0_valid = 1'b1;
      in0_data  = 4'b0010;
      in1_valid = 1'b1;
      in1_data  = 4'b1100;
      out_ready = 1'b1;
      @(negedge clk);
      g = (k % 2 == 0);
      check("tie_r1", int'(in1_ready), int'(g));
      check("tie_r0", int'(in0_ready), int'(!g));
      if (k > 0) begin
        check("tie_ov", int'(out_valid), 1);
        check("tie_src", int'(out_src), int'(!g));
        check("tie_gray", int'(out_gray), g ? 4'b0011 : 4'b1010);
      end
    end

    // Backpressure with the slot holding port 0's word.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      check("bp_r0", int'(in0_ready), 0);
      check("bp_r1", int'(in1_ready), 0);
      check("bp_gray", int'(out_gray), 4'b0011);
      check("bp_src", int'(out_src), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_r1", int'(in1_ready), 1);
    check("bp_release_r0", int'(in0_ready), 0);
    @(posedge clk); #1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    @(negedge clk);
    check("bp_after_src", int'(out_src), 1);
    check("bp_after_gray", int'(out_gray), 4'b1010);

    // Exhaustive sweep from a fresh count.
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in1_valid = 1'b1;
      in1_data  = 4'(i);
      @(negedge clk);
      check("sweep_r1", int'(in1_ready), 1);
      if (i > 0) check($sformatf("sweep_gray%0d", i-1), int'(out_gray), int'(gray_ref(4'(i-1))));
    end
    @(posedge clk); #1;
    in1_valid = 1'b0;
    @(negedge clk);
    check("sweep_gray15", int'(out_gray), 4'b1000);
    check("sweep_cnt16", int'(xfer_cnt), 16);

    // Counter wrap: 240 more accepts bring the total to 256.
    for (int i = 0; i < 240; i++) begin
      @(posedge clk); #1;
      in0_valid = 1'b1;
      in0_data  = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    check("wrap_cnt", int'(xfer_cnt), 0);

    // Asynchronous reset while a result is held.
    @(posedge clk); #1;
    in0_valid = 1'b1;
    in0_data  = 4'h9;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_pre_ov", int'(out_valid), 1);
    check("mid_pre_gray", int'(out_gray), 4'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", int'(out_valid), 0);
    check("mid_rst_cnt", int'(xfer_cnt), 0);
    check("mid_rst_gray", int'(out_gray), 0);
    check("mid_rst_r0", int'(in0_ready), 0);
    check("mid_rst_r1", int'(in1_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in0_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_post_ov", int'(out_valid), 0);
    @(negedge clk);
    check("mid_post_ov2", int'(out_valid), 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
